os_req_tx: RTL and testbench
============================

Name: os_req_tx

Overview:
- Request transmitter for the online-shopping platform. It is the driving end of the shopping input interface that the OS core receives.
- Accepts one complete shopping request per parallel handshake. Serialises it onto the shared 16-bit DATA bus as single-cycle, one-hot valid strobes in protocol order.
- Then holds off until the OS core answers with out_valid.
- Sits between a host/test sequencer and the OS core.

Parameters:
- GAP, 1, idle cycles between consecutive strobes; legal range 1..5.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request offered
- req_ready  out  1  block can accept a request
- req_new_user  in  1  send user id before the action
- req_user  in  8  User_id
- req_act  in  4  Action code
- req_item  in  2  Item_id (Buy/Return)
- req_num  in  6  Item_num (Buy/Return)
- req_seller  in  8  seller User_id (Buy/Return/Check)
- req_seller_en  in  1  Check carries a seller id
- req_amnt  in  16  Money (Deposit)
- req_drop  out  1  1-cycle pulse: request discarded (illegal action)
- id_valid  out  1  D carries a user or seller id
- act_valid  out  1  D carries an action
- item_valid  out  1  D carries an item id
- num_valid  out  1  D carries an item number
- amnt_valid  out  1  D carries a money amount
- D  out  16  DATA bus
- out_valid  in  1  OS core finished the current request

Behaviour:
- Reset (async, rst_n=0): state IDLE, all valids 0, D=0, req_drop=0, req_ready=0 while in reset, first_flag=1. Reset mid-sequence aborts immediately with no further strobes.
- Handshake: req_ready=1 only in IDLE. A transfer occurs on a rising edge with req_valid&&req_ready. All req_* fields are captured at that edge; later changes are ignored.
- Illegal action: req_act not in {1,2,4,8} (including 0):
  - request accepted and dropped;
  - req_drop=1 for the next cycle;
  - state stays IDLE, so req_ready stays 1;
  - first_flag unchanged.
- Strobe sequence; USR is sent if req_new_user=1 or first_flag=1:
  - Buy and Return: [USR] ACT ITEM NUM SEL
  - Check: [USR] ACT [SEL if req_seller_en]
  - Deposit: [USR] ACT AMNT
- Strobe encodings, upper bits zero:
  - USR/SEL: id_valid=1, D={8'd0,id}
  - ACT: act_valid=1, D={12'd0,act}
  - ITEM: item_valid=1, D={14'd0,item}
  - NUM: num_valid=1, D={10'd0,num}
  - AMNT: amnt_valid=1, D=amnt
- first_flag clears when a USR strobe is sent.
- Strobe timing:
  - Exactly one valid high per strobe cycle, for one cycle.
  - D=0 whenever no valid is high.
  - The first strobe is driven in cycle T+1 after the accept edge T.
  - Each following strobe comes GAP+1 cycles after the previous one, i.e. GAP idle cycles between strobes.
- FSM: IDLE -> USR -> ACT -> {ITEM->NUM->SEL | SEL | AMNT}, with a GAP state between strobes (down-counter loaded with GAP-1, 3 bits), then WAIT.
- WAIT is entered the cycle after the last strobe.
  - out_valid sampled 1 in WAIT -> IDLE, so req_ready=1 the following cycle.
  - out_valid while not in WAIT is ignored.
  - No timeout.
- Outputs are registered; no combinational path from req_* to D/valids. req_ready and req_drop decode from registered state.
- Check with req_seller_en=0: the last strobe is ACT.

Test Plan:
- Reset, GAP=1, Buy (act 1), new_user=1, user=8'h05, item=2, num=6'd10, seller=8'h30; accept at T -> id_valid D=16'h0005 @T+1, act_valid D=16'h0001 @T+3, item_valid D=16'h0002 @T+5, num_valid D=16'h000A @T+7, id_valid D=16'h0030 @T+9; req_ready=0 until out_valid, then 1 next cycle.
- After reset, Deposit (act 4) with new_user=0, user=8'h07, amnt=16'hFFFF -> USR still sent (first_flag); a second Deposit with new_user=0 sends only act_valid D=16'h0004 then amnt_valid D=16'hFFFF.
- Check (act 2) with req_seller_en=0 -> single act_valid strobe then WAIT; same request with req_seller_en=1, seller=8'hC8 -> act then id_valid D=16'h00C8.
- req_act=4'd3 -> no valids, req_drop=1 for one cycle, req_ready stays 1; then a legal request sends USR if first_flag is still 1.
- GAP=5, Return (act 8) -> strobes exactly 6 cycles apart; out_valid pulsed mid-sequence is ignored and no early return to IDLE occurs.
- Assert rst_n=0 between ITEM and NUM strobes -> all valids and D go to 0 immediately; after release, req_ready=1 and no stale strobes appear.

Source files
------------

// File: rtl/os_req_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// os_req_tx : serialises one shopping request into one-hot valid strobes on
//             the 16-bit D bus, then holds until the OS core raises out_valid.
// Rev 1.0
// ---------------------------------------------------------------------------
module os_req_tx #(
    parameter int GAP = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_new_user,
    input  logic [7:0]  req_user,
    input  logic [3:0]  req_act,
    input  logic [1:0]  req_item,
    input  logic [5:0]  req_num,
    input  logic [7:0]  req_seller,
    input  logic        req_seller_en,
    input  logic [15:0] req_amnt,
    output logic        req_drop,
    output logic        id_valid,
    output logic        act_valid,
    output logic        item_valid,
    output logic        num_valid,
    output logic        amnt_valid,
    output logic [15:0] D,
    input  logic        out_valid
);
    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_USR  = 4'd1;
    localparam logic [3:0] S_ACT  = 4'd2;
    localparam logic [3:0] S_ITEM = 4'd3;
    localparam logic [3:0] S_NUM  = 4'd4;
    localparam logic [3:0] S_SEL  = 4'd5;
    localparam logic [3:0] S_AMNT = 4'd6;
    localparam logic [3:0] S_GAP  = 4'd7;
    localparam logic [3:0] S_WAIT = 4'd8;

    localparam logic [2:0] GAP_LOAD = 3'(GAP - 1);

    logic [3:0]  state;
    logic [3:0]  next_strobe;
    logic [3:0]  follow;
    logic [2:0]  gap_cnt;
    logic        alive;
    logic        first_flag;
    logic        drop;
    logic        seller_en;
    logic [7:0]  user;
    logic [7:0]  seller;
    logic [3:0]  act;
    logic [1:0]  item;
    logic [5:0]  num;
    logic [15:0] amnt;
    logic        req_legal;
    logic        is_strobe;

    // alive keeps req_ready low for as long as reset is held
    assign req_ready = alive && (state == S_IDLE);
    assign req_drop  = drop;
    assign is_strobe = (state >= S_USR) && (state <= S_AMNT);

    always_comb begin
        case (req_act)
            4'd1, 4'd2, 4'd4, 4'd8: req_legal = 1'b1;
            default:                req_legal = 1'b0;
        endcase
    end

    // Strobe that follows the one being emitted now; S_WAIT marks the last one
    always_comb begin
        follow = S_WAIT;
        case (state)
            S_USR: follow = S_ACT;
            S_ACT: begin
                if (act == 4'd4)
                    follow = S_AMNT;
                else if (act == 4'd2)
                    follow = seller_en ? S_SEL : S_WAIT;
                else
                    follow = S_ITEM;
            end
            S_ITEM:  follow = S_NUM;
            S_NUM:   follow = S_SEL;
            default: follow = S_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            next_strobe <= S_IDLE;
            gap_cnt     <= 3'd0;
            alive       <= 1'b0;
            first_flag  <= 1'b1;
            drop        <= 1'b0;
            seller_en   <= 1'b0;
            user        <= 8'd0;
            seller      <= 8'd0;
            act         <= 4'd0;
            item        <= 2'd0;
            num         <= 6'd0;
            amnt        <= 16'd0;
            id_valid    <= 1'b0;
            act_valid   <= 1'b0;
            item_valid  <= 1'b0;
            num_valid   <= 1'b0;
            amnt_valid  <= 1'b0;
            D           <= 16'd0;
        end else begin
            alive      <= 1'b1;
            drop       <= 1'b0;
            id_valid   <= 1'b0;
            act_valid  <= 1'b0;
            item_valid <= 1'b0;
            num_valid  <= 1'b0;
            amnt_valid <= 1'b0;
            D          <= 16'd0;
            case (state)
                S_IDLE: begin
                    if (req_valid && alive) begin
                        user      <= req_user;
                        act       <= req_act;
                        item      <= req_item;
                        num       <= req_num;
                        seller    <= req_seller;
                        seller_en <= req_seller_en;
                        amnt      <= req_amnt;
                        if (req_legal)
                            state <= (req_new_user || first_flag) ? S_USR : S_ACT;
                        else
                            drop <= 1'b1;
                    end
                end
                S_USR: begin
                    id_valid   <= 1'b1;
                    D          <= {8'd0, user};
                    first_flag <= 1'b0;
                end
                S_ACT: begin
                    act_valid <= 1'b1;
                    D         <= {12'd0, act};
                end
                S_ITEM: begin
                    item_valid <= 1'b1;
                    D          <= {14'd0, item};
                end
                S_NUM: begin
                    num_valid <= 1'b1;
                    D         <= {10'd0, num};
                end
                S_SEL: begin
                    id_valid <= 1'b1;
                    D        <= {8'd0, seller};
                end
                S_AMNT: begin
                    amnt_valid <= 1'b1;
                    D          <= amnt;
                end
                S_GAP: begin
                    if (gap_cnt == 3'd0)
                        state <= next_strobe;
                    else
                        gap_cnt <= gap_cnt - 3'd1;
                end
                S_WAIT: begin
                    if (out_valid)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
            if (is_strobe) begin
                if (follow == S_WAIT) begin
                    state <= S_WAIT;
                end else begin
                    state       <= S_GAP;
                    next_strobe <= follow;
                    gap_cnt     <= GAP_LOAD;
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_os_req_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_os_req_tx : scoreboard bench driving a GAP=1 and a GAP=5 instance in lockstep.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_os_req_tx;
    typedef struct {
        int          kind;   // 0 id,1 act,2 item,3 num,4 amnt,5 drop
        logic [15:0] d;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_new_user = 1'b0;
    logic [7:0]  req_user = 8'd0;
    logic [3:0]  req_act = 4'd0;
    logic [1:0]  req_item = 2'd0;
    logic [5:0]  req_num = 6'd0;
    logic [7:0]  req_seller = 8'd0;
    logic        req_seller_en = 1'b0;
    logic [15:0] req_amnt = 16'd0;
    logic        out_valid = 1'b0;

    logic        rdy[2], drp[2], idv[2], acv[2], itv[2], nmv[2], amv[2];
    logic [15:0] dbus[2];

    exp_t q0[$];
    exp_t q1[$];
    int   last_t[2];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   ff = 1'b1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    os_req_tx #(.GAP(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy[0]),
        .req_new_user(req_new_user), .req_user(req_user), .req_act(req_act),
        .req_item(req_item), .req_num(req_num), .req_seller(req_seller),
        .req_seller_en(req_seller_en), .req_amnt(req_amnt), .req_drop(drp[0]),
        .id_valid(idv[0]), .act_valid(acv[0]), .item_valid(itv[0]),
        .num_valid(nmv[0]), .amnt_valid(amv[0]), .D(dbus[0]), .out_valid(out_valid)
    );

    os_req_tx #(.GAP(5)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy[1]),
        .req_new_user(req_new_user), .req_user(req_user), .req_act(req_act),
        .req_item(req_item), .req_num(req_num), .req_seller(req_seller),
        .req_seller_en(req_seller_en), .req_amnt(req_amnt), .req_drop(drp[1]),
        .id_valid(idv[1]), .act_valid(acv[1]), .item_valid(itv[1]),
        .num_valid(nmv[1]), .amnt_valid(amv[1]), .D(dbus[1]), .out_valid(out_valid)
    );

    task automatic push(input int k, input int kind, input logic [15:0] d, input int t);
        exp_t e;
        e.kind = kind;
        e.d    = d;
        e.cyc  = t;
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic mon(input int k);
        logic [5:0] v;
        exp_t       e;
        int         kind;
        bit         empty;
        v = {drp[k], amv[k], nmv[k], itv[k], acv[k], idv[k]};
        checks++;
        if ($countones(v) > 1) begin
            errors++;
            $display("FAIL onehot dut%0d cyc=%0d: valids=%b, required at most one high", k, cyc, v);
        end
        if (v[4:0] == 5'd0) begin
            checks++;
            if (dbus[k] !== 16'd0) begin
                errors++;
                $display("FAIL d_idle dut%0d cyc=%0d: D=%h, required 0000", k, cyc, dbus[k]);
            end
        end
        if ($countones(v) == 1) begin
            kind = 0;
            for (int i = 0; i < 6; i++) if (v[i]) kind = i;
            checks++;
            empty = (k == 0) ? (q0.size() == 0) : (q1.size() == 0);
            if (empty) begin
                errors++;
                $display("FAIL unexpected dut%0d cyc=%0d: kind=%0d D=%h, required no strobe", k, cyc, kind, dbus[k]);
            end else begin
                e = (k == 0) ? q0.pop_front() : q1.pop_front();
                if (kind != e.kind || dbus[k] !== e.d || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL strobe dut%0d: got kind=%0d D=%h cyc=%0d, required kind=%0d D=%h cyc=%0d",
                             k, kind, dbus[k], cyc, e.kind, e.d, e.cyc);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    task automatic check_quiet(input string name, input logic rdy_req);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({drp[k], idv[k], acv[k], itv[k], nmv[k], amv[k]} !== 6'd0 ||
                dbus[k] !== 16'd0 || rdy[k] !== rdy_req) begin
                errors++;
                $display("FAIL %s dut%0d: valids=%b D=%h ready=%b, required 0 0000 ready=%b", name, k,
                         {drp[k], idv[k], acv[k], itv[k], nmv[k], amv[k]}, dbus[k], rdy[k], rdy_req);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        q0.delete();
        q1.delete();
        ff = 1'b1;
        #1 check_quiet("in_reset", 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_quiet("after_reset", 1'b1);
    endtask

    task automatic send(input logic nu, input logic [7:0] u, input logic [3:0] a,
                        input logic [1:0] it, input logic [5:0] nm, input logic [7:0] s,
                        input logic se, input logic [15:0] am);
        int  w, t, g, tacc;
        bit  legal, usr;
        w = 0;
        @(negedge clk);
        while (!(rdy[0] && rdy[1]) && w < 200) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (!(rdy[0] && rdy[1])) begin
            errors++;
            $display("FAIL ready_before_accept: ready=%b%b, required 11", rdy[1], rdy[0]);
        end
        req_valid = 1'b1; req_new_user = nu; req_user = u; req_act = a; req_item = it;
        req_num = nm; req_seller = s; req_seller_en = se; req_amnt = am;
        tacc  = cyc + 1;
        legal = (a == 4'd1) || (a == 4'd2) || (a == 4'd4) || (a == 4'd8);
        usr   = nu || ff;
        for (int k = 0; k < 2; k++) begin
            g = (k == 0) ? 1 : 5;
            t = tacc + 1;
            if (!legal) begin
                push(k, 5, 16'd0, tacc);
            end else begin
                if (usr) begin push(k, 0, {8'd0, u}, t); t += g + 1; end
                push(k, 1, {12'd0, a}, t); last_t[k] = t; t += g + 1;
                if (a == 4'd1 || a == 4'd8) begin
                    push(k, 2, {14'd0, it}, t); t += g + 1;
                    push(k, 3, {10'd0, nm}, t); t += g + 1;
                    push(k, 0, {8'd0, s}, t);   last_t[k] = t;
                end else if (a == 4'd2 && se) begin
                    push(k, 0, {8'd0, s}, t);   last_t[k] = t;
                end else if (a == 4'd4) begin
                    push(k, 4, am, t);          last_t[k] = t;
                end
            end
        end
        if (legal && usr) ff = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_user = ~u; req_act = ~a; req_item = ~it; req_num = ~nm;
        req_seller = ~s; req_seller_en = ~se; req_amnt = ~am; req_new_user = ~nu;
        checks++;
        if (rdy[0] !== !legal || rdy[1] !== !legal) begin
            errors++;
            $display("FAIL ready_after_accept: ready=%b%b, required %b%b", rdy[1], rdy[0], !legal, !legal);
        end
    endtask

    task automatic finish_req();
        int w;
        w = 0;
        while (cyc <= last_t[1] + 1 && w < 500) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (rdy[0] || rdy[1]) begin
            errors++;
            $display("FAIL ready_in_wait: ready=%b%b, required 00", rdy[1], rdy[0]);
        end
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL missing_strobe: pending=%0d/%0d, required 0/0", q0.size(), q1.size());
        end
        out_valid = 1'b1;
        @(negedge clk);
        out_valid = 1'b0;
        checks++;
        if (!(rdy[0] && rdy[1])) begin
            errors++;
            $display("FAIL ready_after_out_valid: ready=%b%b, required 11", rdy[1], rdy[0]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();
        // Buy with new user
        send(1'b1, 8'h05, 4'd1, 2'd2, 6'd10, 8'h30, 1'b0, 16'h1234);
        finish_req();

        // Two deposits after reset: first still sends USR
        do_reset();
        send(1'b0, 8'h07, 4'd4, 2'd0, 6'd0, 8'h00, 1'b0, 16'hFFFF);
        finish_req();
        send(1'b0, 8'h07, 4'd4, 2'd0, 6'd0, 8'h00, 1'b0, 16'hFFFF);
        finish_req();

        // Check without and with seller
        send(1'b0, 8'h07, 4'd2, 2'd0, 6'd0, 8'hC8, 1'b0, 16'h0000);
        finish_req();
        send(1'b0, 8'h07, 4'd2, 2'd0, 6'd0, 8'hC8, 1'b1, 16'h0000);
        finish_req();

        // Illegal action dropped, first_flag kept
        do_reset();
        send(1'b0, 8'h11, 4'd3, 2'd1, 6'd1, 8'h22, 1'b0, 16'h0000);
        send(1'b0, 8'h11, 4'd2, 2'd1, 6'd1, 8'h22, 1'b0, 16'h0000);
        finish_req();

        // Return with an out_valid pulse mid-sequence
        send(1'b1, 8'h3C, 4'd8, 2'd3, 6'd63, 8'hA5, 1'b0, 16'h0000);
        repeat (4) @(negedge clk);
        out_valid = 1'b1;
        @(negedge clk);
        out_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (rdy[0] || rdy[1]) begin
            errors++;
            $display("FAIL early_return: ready=%b%b, required 00", rdy[1], rdy[0]);
        end
        finish_req();

        // Reset between ITEM and NUM of the GAP=1 instance
        send(1'b1, 8'h42, 4'd1, 2'd1, 6'd5, 8'h99, 1'b0, 16'h0000);
        repeat (5) @(negedge clk);
        do_reset();
        repeat (20) @(negedge clk);
        check_quiet("post_abort", 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
